// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RISC-V size/sign codes,
// FSM state encoding and the default data-memory size.
package lsu_pkg;

    localparam int MEM_BYTES_DEFAULT = 64;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STORE_RD,
        ST_STORE_WR,
        ST_RESP
    } lsu_state_e;

    // Access width in bytes; the low two funct3 bits encode log2(size).
    function automatic logic [3:0] access_bytes(input logic [2:0] funct3);
        return 4'd1 << funct3[1:0];
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational data alignment: extends a loaded doubleword to the requested
// size/sign and merges a narrow store into the doubleword read from memory.
module lsu_align (
    input  logic [2:0]  funct3,
    input  logic [63:0] rd_data,
    input  logic [63:0] st_data,
    output logic [63:0] load_data,
    output logic [63:0] merge_data
);
    import lsu_pkg::*;

    logic [3:0] n_bytes;

    assign n_bytes = access_bytes(funct3);

    always_comb begin
        load_data = '0;
        case (funct3)
            F3_B:    load_data = {{56{rd_data[7]}},  rd_data[7:0]};
            F3_H:    load_data = {{48{rd_data[15]}}, rd_data[15:0]};
            F3_W:    load_data = {{32{rd_data[31]}}, rd_data[31:0]};
            F3_D:    load_data = rd_data;
            F3_BU:   load_data = {56'd0, rd_data[7:0]};
            F3_HU:   load_data = {48'd0, rd_data[15:0]};
            F3_WU:   load_data = {32'd0, rd_data[31:0]};
            default: load_data = '0;
        endcase
    end

    // Bytes below the access size come from the store data, the rest are kept.
    for (genvar gi = 0; gi < 8; gi++) begin : g_merge
        localparam logic [3:0] BYTE_IDX = 4'(gi);
        assign merge_data[8*gi +: 8] = (BYTE_IDX < n_bytes) ? st_data[8*gi +: 8]
                                                            : rd_data[8*gi +: 8];
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit between a pipeline and a doubleword data
// memory; narrow stores use a read-modify-write of the containing doubleword.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_BYTES = MEM_BYTES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_error,
    output logic [63:0] Mem_Addr,
    output logic [63:0] Write_Data,
    output logic        MemWrite,
    output logic        MemRead,
    input  logic [63:0] Read_Data
);

    lsu_state_e  state_reg, state_next;
    logic        write_reg;
    logic [2:0]  funct3_reg;
    logic [63:0] addr_reg;
    logic [63:0] data_reg;
    logic        err_reg;

    logic        accept;
    logic        req_err;
    logic [3:0]  req_bytes;
    logic        misalign_err;
    logic        range_err;
    logic        funct_err;
    logic [63:0] load_data;
    logic [63:0] merge_data;

    assign accept    = req_valid && (state_reg == ST_IDLE);
    assign req_bytes = access_bytes(req_funct3);

    assign misalign_err = (req_addr[2:0] & 3'(req_bytes - 4'd1)) != 3'd0;
    assign range_err    = req_addr > 64'(MEM_BYTES - 8);
    assign funct_err    = req_write ? req_funct3[2] : (req_funct3 == 3'b111);
    assign req_err      = misalign_err || range_err || funct_err;

    lsu_align u_align (
        .funct3     (funct3_reg),
        .rd_data    (Read_Data),
        .st_data    (data_reg),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    if (req_err)
                        state_next = ST_RESP;
                    else if (!req_write)
                        state_next = ST_LOAD;
                    else if (req_funct3 == F3_D)
                        state_next = ST_STORE_WR;
                    else
                        state_next = ST_STORE_RD;
                end
            end
            ST_LOAD:     state_next = ST_RESP;
            ST_STORE_RD: state_next = ST_STORE_WR;
            ST_STORE_WR: state_next = ST_RESP;
            ST_RESP:     state_next = ST_IDLE;
            default:     state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // data_reg holds the store data, then the merged doubleword or the load result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_reg  <= 1'b0;
            funct3_reg <= '0;
            addr_reg   <= '0;
            data_reg   <= '0;
            err_reg    <= 1'b0;
        end else begin
            if (accept) begin
                write_reg  <= req_write;
                funct3_reg <= req_funct3;
                addr_reg   <= req_addr;
                data_reg   <= req_wdata;
                err_reg    <= req_err;
            end else if (state_reg == ST_LOAD) begin
                data_reg <= load_data;
            end else if (state_reg == ST_STORE_RD) begin
                data_reg <= merge_data;
            end
        end
    end

    always_comb begin
        req_ready  = (state_reg == ST_IDLE);
        MemRead    = (state_reg == ST_LOAD) || (state_reg == ST_STORE_RD);
        MemWrite   = (state_reg == ST_STORE_WR);
        Mem_Addr   = (state_reg == ST_IDLE) ? 64'd0 : addr_reg;
        Write_Data = (state_reg == ST_STORE_WR) ? data_reg : 64'd0;
        resp_valid = (state_reg == ST_RESP);
        resp_error = (state_reg == ST_RESP) && err_reg;
        resp_rdata = ((state_reg == ST_RESP) && !write_reg && !err_reg) ? data_reg : 64'd0;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized and directed bench for load_store_unit against a byte-array
// reference model of the data memory.
module tb_load_store_unit;

    localparam int MEM = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_error;
    logic [63:0] Mem_Addr;
    logic [63:0] Write_Data;
    logic        MemWrite;
    logic        MemRead;
    logic [63:0] Read_Data;

    int n_compared = 0;
    int n_mismatch = 0;

    logic [7:0] dmem    [MEM];
    logic [7:0] ref_mem [MEM];

    int          rd_cnt = 0;
    int          wr_cnt = 0;
    logic [63:0] last_wdata = '0;
    logic [63:0] last_waddr = '0;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_BYTES(MEM)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_error (resp_error),
        .Mem_Addr   (Mem_Addr),
        .Write_Data (Write_Data),
        .MemWrite   (MemWrite),
        .MemRead    (MemRead),
        .Read_Data  (Read_Data)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatch++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always_comb begin
        Read_Data = '0;
        for (int i = 0; i < 8; i++)
            if (Mem_Addr + 64'(i) < 64'(MEM))
                Read_Data[8*i +: 8] = dmem[int'(Mem_Addr) + i];
    end

    // Memory side: counts strobes and performs doubleword writes.
    always @(negedge clk) begin
        if (MemRead && MemWrite)
            check_eq("rd_wr_overlap", 64'(MemWrite), 64'd0);
        if (MemRead)
            rd_cnt++;
        if (MemWrite) begin
            wr_cnt++;
            last_wdata = Write_Data;
            last_waddr = Mem_Addr;
            for (int i = 0; i < 8; i++)
                if (Mem_Addr + 64'(i) < 64'(MEM))
                    dmem[int'(Mem_Addr) + i] = Write_Data[8*i +: 8];
        end
    end

    // Reference behaviour straight from the access rules, on ref_mem.
    task automatic model(input bit w, input logic [2:0] f3, input logic [63:0] addr,
                         input logic [63:0] wd, output bit err, output logic [63:0] rdata,
                         output int lat, output int nrd, output int nwr,
                         output logic [63:0] wimg);
        int size;
        int a;
        logic [63:0] val;
        size  = 1 << f3[1:0];
        err   = (addr % 64'(size) != 0) || (addr > 64'(MEM - 8)) ||
                (!w && f3 == 3'd7) || (w && f3 >= 3'd4);
        rdata = '0;
        wimg  = '0;
        lat = 1; nrd = 0; nwr = 0;
        if (!err) begin
            a = int'(addr);
            if (!w) begin
                val = '0;
                for (int i = 0; i < size; i++)
                    val = val | (64'(ref_mem[a + i]) << (8 * i));
                if (f3 < 3'd4 && size < 8 && val[8*size-1])
                    val = val | (~64'd0 << (8 * size));
                rdata = val;
                lat = 2; nrd = 1;
            end else begin
                for (int i = 0; i < size; i++)
                    ref_mem[a + i] = wd[8*i +: 8];
                for (int i = 0; i < 8; i++)
                    wimg[8*i +: 8] = ref_mem[a + i];
                lat = (size == 8) ? 2 : 3;
                nrd = (size == 8) ? 0 : 1;
                nwr = 1;
            end
        end
    endtask

    task automatic do_req(input string name, input bit w, input logic [2:0] f3,
                          input logic [63:0] addr, input logic [63:0] wd,
                          output logic [63:0] got_rdata);
        bit e_err;
        logic [63:0] e_rdata, e_wimg;
        int e_lat, e_rd, e_wr, t, k;
        bit got;
        logic got_err;
        got_rdata = '0;
        got_err = 1'b0;
        model(w, f3, addr, wd, e_err, e_rdata, e_lat, e_rd, e_wr, e_wimg);
        @(negedge clk);
        t = 0;
        while (!req_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) begin
            check_eq({name, "_ready_timeout"}, 64'(req_ready), 64'd1);
            return;
        end
        req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        rd_cnt = 0; wr_cnt = 0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        k = 0; got = 1'b0;
        while (k < 10 && !got) begin
            @(negedge clk);
            k++;
            if (resp_valid) begin
                got = 1'b1;
                got_rdata = resp_rdata;
                got_err = resp_error;
            end
        end
        if (!got) begin
            check_eq({name, "_resp_timeout"}, 64'(got), 64'd1);
            return;
        end
        check_eq({name, "_latency"}, 64'(k), 64'(e_lat));
        check_eq({name, "_error"}, 64'(got_err), 64'(e_err));
        check_eq({name, "_rdata"}, got_rdata, e_rdata);
        check_eq({name, "_reads"}, 64'(rd_cnt), 64'(e_rd));
        check_eq({name, "_writes"}, 64'(wr_cnt), 64'(e_wr));
        if (wr_cnt == 1 && e_wr == 1) begin
            check_eq({name, "_wdata"}, last_wdata, e_wimg);
            check_eq({name, "_waddr"}, last_waddr, addr);
        end
        @(negedge clk);
        check_eq({name, "_resp_one_cycle"}, 64'(resp_valid), 64'd0);
        $display("txn %s: w=%0d f3=%0d addr=%0d wdata=%h -> rdata=%h err=%0d lat=%0d",
                 name, w, f3, addr, wd, got_rdata, got_err, k);
    endtask

    initial begin
        logic [63:0] r;
        logic [63:0] q_addr [3];
        logic [2:0]  q_f3 [3];
        logic [63:0] q_exp [3];
        int          q_cyc [3];
        logic [63:0] q_got [3];
        int          idx, nresp;
        bit          ready_b;
        bit          e_err;
        int          e_lat, e_rd, e_wr;
        logic [63:0] e_wimg;

        for (int i = 0; i < MEM; i++) begin
            dmem[i] = 8'd0;
            ref_mem[i] = 8'd0;
        end
        dmem[0] = 8'd3;  ref_mem[0] = 8'd3;
        dmem[1] = 8'd2;  ref_mem[1] = 8'd2;
        dmem[8] = 8'd5;  ref_mem[8] = 8'd5;
        dmem[16] = 8'd4; ref_mem[16] = 8'd4;
        dmem[24] = 8'd7; ref_mem[24] = 8'd7;

        #12;
        check_eq("rst_ready", 64'(req_ready), 64'd1);
        check_eq("rst_resp_valid", 64'(resp_valid), 64'd0);
        check_eq("rst_resp_error", 64'(resp_error), 64'd0);
        check_eq("rst_strobes", {62'd0, MemRead, MemWrite}, 64'd0);
        check_eq("rst_rdata", resp_rdata, 64'd0);
        check_eq("rst_mem_addr", Mem_Addr, 64'd0);
        check_eq("rst_write_data", Write_Data, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_req("ld0", 1'b0, 3'b011, 64'd0, 64'd0, r);
        check_eq("ld0_value", r, 64'h0203);
        do_req("lb8", 1'b0, 3'b000, 64'd8, 64'd0, r);
        check_eq("lb8_value", r, 64'd5);
        do_req("sb16", 1'b1, 3'b000, 64'd16, 64'hFF, r);
        check_eq("sb16_mem", last_wdata, 64'hFF);
        do_req("lb16", 1'b0, 3'b000, 64'd16, 64'd0, r);
        check_eq("lb16_value", r, 64'hFFFF_FFFF_FFFF_FFFF);
        do_req("lbu16", 1'b0, 3'b100, 64'd16, 64'd0, r);
        check_eq("lbu16_value", r, 64'hFF);
        do_req("ld16", 1'b0, 3'b011, 64'd16, 64'd0, r);
        check_eq("ld16_value", r, 64'hFF);
        do_req("lw2_err", 1'b0, 3'b010, 64'd2, 64'd0, r);
        do_req("sd60_err", 1'b1, 3'b011, 64'd60, 64'h1234, r);

        // Three loads back to back with req_valid never dropped.
        q_addr[0] = 64'd0;  q_f3[0] = 3'b011;
        q_addr[1] = 64'd8;  q_f3[1] = 3'b000;
        q_addr[2] = 64'd16; q_f3[2] = 3'b100;
        for (int i = 0; i < 3; i++)
            model(1'b0, q_f3[i], q_addr[i], 64'd0, e_err, q_exp[i], e_lat, e_rd, e_wr, e_wimg);
        @(negedge clk);
        idx = 0; nresp = 0;
        req_valid = 1'b1; req_write = 1'b0; req_funct3 = q_f3[0]; req_addr = q_addr[0];
        for (int c = 0; c < 30 && nresp < 3; c++) begin
            ready_b = req_ready;
            @(posedge clk);
            #1;
            if (ready_b && req_valid && idx < 3) begin
                idx++;
                if (idx < 3) begin
                    req_funct3 = q_f3[idx];
                    req_addr = q_addr[idx];
                end else begin
                    req_valid = 1'b0;
                end
            end
            @(negedge clk);
            if (resp_valid) begin
                q_cyc[nresp] = c;
                q_got[nresp] = resp_rdata;
                nresp++;
            end
        end
        req_valid = 1'b0;
        check_eq("queue_count", 64'(nresp), 64'd3);
        if (nresp == 3) begin
            for (int i = 0; i < 3; i++)
                check_eq($sformatf("queue_rdata%0d", i), q_got[i], q_exp[i]);
            check_eq("queue_gap01", 64'(q_cyc[1] - q_cyc[0]), 64'd3);
            check_eq("queue_gap12", 64'(q_cyc[2] - q_cyc[1]), 64'd3);
        end
        $display("txn queue: %0d responses", nresp);

        // Reset while the sh read-modify-write is in its read phase.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b001; req_addr = 64'd24;
        req_wdata = 64'hABCD;
        wr_cnt = 0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        check_eq("sh24_store_rd", 64'(MemRead), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("sh24_rst_ready", 64'(req_ready), 64'd1);
        check_eq("sh24_rst_addr", Mem_Addr, 64'd0);
        check_eq("sh24_rst_strobes", {62'd0, MemRead, MemWrite}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("sh24_no_write", 64'(wr_cnt), 64'd0);
        $display("txn sh24_reset: writes=%0d", wr_cnt);
        do_req("lb24", 1'b0, 3'b000, 64'd24, 64'd0, r);
        check_eq("lb24_value", r, 64'd7);

        do_req("sd40", 1'b1, 3'b011, 64'd40, 64'h1122334455667788, r);
        do_req("ld40", 1'b0, 3'b011, 64'd40, 64'd0, r);
        check_eq("ld40_value", r, 64'h1122334455667788);

        for (int n = 0; n < 40; n++) begin
            bit w;
            logic [2:0] f3;
            logic [63:0] addr;
            int size;
            w = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            size = 1 << f3[1:0];
            if ($urandom_range(0, 7) == 0)
                addr = 64'($urandom_range(0, MEM + 8));
            else
                addr = 64'($urandom_range(0, MEM - 8)) & ~64'(size - 1);
            do_req($sformatf("rnd%0d", n), w, f3, addr, {$urandom, $urandom}, r);
        end

        for (int i = 0; i < MEM; i++)
            if (dmem[i] !== ref_mem[i])
                check_eq($sformatf("final_mem%0d", i), 64'(dmem[i]), 64'(ref_mem[i]));
        check_eq("final_idle", 64'(req_ready), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
